// File: rtl/nv_ram_rws_rd_ctrl.sv
// Read-side client for a 1R1W RAM with a registered read address.
// Issues RAM reads for accepted requests, captures ram_dout one cycle after
// each read enable into a 3-entry buffer, and returns the data in request
// order over a valid/ready response port.
module nv_ram_rws_rd_ctrl #(
  parameter int AW = 7,
  parameter int DW = 512
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          rd_req_pvld,
  output logic          rd_req_prdy,
  input  logic [AW-1:0] rd_req_addr,
  output logic          ram_re,
  output logic [AW-1:0] ram_ra,
  input  logic [DW-1:0] ram_dout,
  output logic          rd_rsp_pvld,
  input  logic          rd_rsp_prdy,
  output logic [DW-1:0] rd_rsp_data,
  output logic          rd_idle
);

  // Buffer bookkeeping: occupancy count, ring pointers and the one-cycle
  // "read issued last cycle" flag that marks ram_dout as capturable.
  logic [1:0]    r_cnt;
  logic [1:0]    r_wrPtr;
  logic [1:0]    r_rdPtr;
  logic          r_inflight;

  // Three response slots; contents are don't-care until written.
  logic [DW-1:0] r_buf0;
  logic [DW-1:0] r_buf1;
  logic [DW-1:0] r_buf2;

  logic [2:0]    w_occupancy;
  logic          w_reqPrdy;
  logic          w_accept;
  logic          w_rspPvld;
  logic          w_pop;
  logic [1:0]    w_cntNext;
  logic [DW-1:0] w_rspData;

  // Ring pointers cycle 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] nextPtr(input logic [1:0] ptr);
    return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  endfunction

  // Request/response handshakes. Ready only looks at registered state so that
  // a read is accepted only when a slot is guaranteed for its data.
  always_comb begin
    w_occupancy = {1'b0, r_cnt} + {2'b00, r_inflight};
    w_reqPrdy   = nvdla_core_rstn & (w_occupancy < 3'd3);
    w_accept    = rd_req_pvld & w_reqPrdy;
    w_rspPvld   = nvdla_core_rstn & (r_cnt != 2'd0);
    w_pop       = w_rspPvld & rd_rsp_prdy;
  end

  // Occupancy update: a capture and a pop in the same cycle cancel out.
  always_comb begin
    w_cntNext = r_cnt;
    case ({r_inflight, w_pop})
      2'b10:   w_cntNext = r_cnt + 2'd1;
      2'b01:   w_cntNext = r_cnt - 2'd1;
      default: w_cntNext = r_cnt;
    endcase
  end

  // Response data always comes from the buffer head, never straight from ram_dout.
  always_comb begin
    w_rspData = r_buf0;
    case (r_rdPtr)
      2'd1:    w_rspData = r_buf1;
      2'd2:    w_rspData = r_buf2;
      default: w_rspData = r_buf0;
    endcase
  end

  // Control state; reset drops any buffered or in-flight reads.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      r_cnt      <= 2'd0;
      r_wrPtr    <= 2'd0;
      r_rdPtr    <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_cnt      <= w_cntNext;
      r_inflight <= w_accept;
      if (r_inflight) begin
        r_wrPtr <= nextPtr(r_wrPtr);
      end
      if (w_pop) begin
        r_rdPtr <= nextPtr(r_rdPtr);
      end
    end
  end

  // Sample ram_dout exactly once, in the cycle after the read enable, so later
  // RAM writes to the same address cannot disturb data already buffered.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rstn && r_inflight) begin
      case (r_wrPtr)
        2'd1:    r_buf1 <= ram_dout;
        2'd2:    r_buf2 <= ram_dout;
        default: r_buf0 <= ram_dout;
      endcase
    end
  end

  assign rd_req_prdy = w_reqPrdy;
  assign ram_re      = w_accept;
  assign ram_ra      = rd_req_addr;
  assign rd_rsp_pvld = w_rspPvld;
  assign rd_rsp_data = w_rspData;
  assign rd_idle     = (r_cnt == 2'd0) & ~r_inflight;

  // Buffered plus in-flight reads never exceed the three slots.
  a_occupancyBound : assert property (@(posedge nvdla_core_clk)
    disable iff (!nvdla_core_rstn) w_occupancy <= 3'd3);

  // A capture only happens when a slot was reserved for it.
  a_captureHasSlot : assert property (@(posedge nvdla_core_clk)
    disable iff (!nvdla_core_rstn) r_inflight |-> ({1'b0, r_cnt} <= 3'd2));

  // Pointers stay inside the three-entry ring.
  a_ptrLegal : assert property (@(posedge nvdla_core_clk)
    disable iff (!nvdla_core_rstn) (r_wrPtr != 2'd3) && (r_rdPtr != 2'd3));

  // A stalled response holds its data.
  a_stallStable : assert property (@(posedge nvdla_core_clk)
    disable iff (!nvdla_core_rstn)
    (rd_rsp_pvld && !rd_rsp_prdy) |=> $stable(rd_rsp_data));

endmodule
